// File: rtl/wb_ram_responder.sv
// Pipelined Wishbone slave with a word-addressed RAM that zeroes itself after reset.
// Acks come back in order a fixed LATENCY cycles after acceptance; dropping
// i_wb_cycle kills every in-flight response.
module wb_ram_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wb_cycle,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [29:0] i_wb_addr,
   input  logic [31:0] i_wb_mosi_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_miso_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {ST_INIT, ST_READY} state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      init_cnt_q, init_cnt_d;
   logic [31:0]        mem_q [DEPTH];

   logic [LATENCY-1:0] valid_q, valid_d;
   logic [LATENCY-1:0] read_q, read_d;
   logic [31:0]        data_q [LATENCY];
   logic [31:0]        data_d [LATENCY];

   logic               accept;
   logic               in_range;
   logic               wr_en;
   logic [AW-1:0]      idx;
   logic [31:0]        rd_word;

   // Request decode; stall is a pure function of the state register
   assign o_wb_stall = (state_q == ST_INIT);
   assign accept     = i_wb_cycle & i_wb_stb & ~o_wb_stall;
   assign idx        = i_wb_addr[AW-1:0];
   assign in_range   = ({2'b00, i_wb_addr} < 32'(DEPTH));
   assign wr_en      = accept & i_wb_we & in_range;
   assign rd_word    = in_range ? mem_q[idx] : 32'h0;

   // State and init counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // INIT sweeps every word once, then READY holds until the next reset
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + AW'(1);
            if (init_cnt_q == AW'(DEPTH - 1)) begin
               state_d = ST_READY;
            end
         end
         ST_READY: state_d = ST_READY;
         default:  state_d = ST_INIT;
      endcase
   end

   // RAM: zero fill during INIT, byte-masked writes once READY
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[init_cnt_q] <= 32'h0;
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wb_sel[b]) begin
               mem_q[idx][8*b +: 8] <= i_wb_mosi_data[8*b +: 8];
            end
         end
      end
   end

   // Response pipeline: read data is captured at acceptance and shifted along
   always_comb begin
      valid_d = valid_q;
      read_d  = read_q;
      data_d  = data_q;
      for (int i = int'(LATENCY) - 1; i > 0; i--) begin
         valid_d[i] = valid_q[i-1];
         read_d[i]  = read_q[i-1];
         data_d[i]  = data_q[i-1];
      end
      valid_d[0] = accept;
      read_d[0]  = accept & ~i_wb_we;
      data_d[0]  = (accept & ~i_wb_we) ? rd_word : 32'h0;
      if (!i_wb_cycle) begin
         valid_d = '0;
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         read_q  <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            data_q[i] <= 32'h0;
         end
      end else begin
         valid_q <= valid_d;
         read_q  <= read_d;
         data_q  <= data_d;
      end
   end

   // Ack is masked by the live cycle so nothing leaks out after an abort
   assign o_wb_ack       = valid_q[LATENCY-1] & i_wb_cycle;
   assign o_wb_miso_data = (o_wb_ack & read_q[LATENCY-1]) ? data_q[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Bench for wb_ram_responder: two instances (LATENCY 2 and 3, DEPTH 16) share
// one stimulus stream and are compared every cycle against a due-time model.
module tb_wb_ram_responder;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_wb_cycle = 1'b0;
   logic        i_wb_stb = 1'b0;
   logic        i_wb_we = 1'b0;
   logic [3:0]  i_wb_sel = 4'h0;
   logic [29:0] i_wb_addr = 30'h0;
   logic [31:0] i_wb_mosi_data = 32'h0;

   logic        ack2, stall2, ack3, stall3;
   logic [31:0] miso2, miso3;

   int checks = 0;
   int failures = 0;

   logic [67:0] act, exp;

   always #5 clk = ~clk;

   wb_ram_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
      .clk(clk), .reset(reset), .i_wb_cycle(i_wb_cycle), .i_wb_stb(i_wb_stb),
      .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_addr(i_wb_addr),
      .i_wb_mosi_data(i_wb_mosi_data), .o_wb_ack(ack2), .o_wb_stall(stall2),
      .o_wb_miso_data(miso2)
   );

   wb_ram_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .i_wb_cycle(i_wb_cycle), .i_wb_stb(i_wb_stb),
      .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel), .i_wb_addr(i_wb_addr),
      .i_wb_mosi_data(i_wb_mosi_data), .o_wb_ack(ack3), .o_wb_stall(stall3),
      .o_wb_miso_data(miso3)
   );

   // Reference model: each accepted request becomes a pending response with the
   // edge number after which its ack must be visible.
   typedef struct {
      int          due;
      logic [31:0] data;
   } pend_t;

   pend_t       q2[$];
   pend_t       q3[$];
   logic [31:0] mmem [DEPTH];
   int          edge_n = 0;
   int          init_left = DEPTH;
   logic        m_acc;
   logic [31:0] m_rd;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_left = DEPTH;
         q2.delete();
         q3.delete();
         for (int a = 0; a < DEPTH; a++) mmem[a] = 32'h0;
      end else begin
         edge_n++;
         m_acc = i_wb_cycle && i_wb_stb && (init_left == 0);
         if (init_left > 0) init_left--;
         if (!i_wb_cycle) begin
            q2.delete();
            q3.delete();
         end
         while (q2.size() > 0 && q2[0].due < edge_n) void'(q2.pop_front());
         while (q3.size() > 0 && q3[0].due < edge_n) void'(q3.pop_front());
         if (m_acc) begin
            m_rd = 32'h0;
            if (i_wb_addr < 30'(DEPTH)) begin
               if (i_wb_we) begin
                  for (int b = 0; b < 4; b++)
                     if (i_wb_sel[b]) mmem[i_wb_addr[3:0]][8*b +: 8] = i_wb_mosi_data[8*b +: 8];
               end else begin
                  m_rd = mmem[i_wb_addr[3:0]];
               end
            end
            q2.push_back('{edge_n + 1, m_rd});
            q3.push_back('{edge_n + 2, m_rd});
         end
      end
   end

   // Expected {stall2, stall3, ack2, ack3, miso2, miso3} for the current cycle
   function automatic logic [67:0] expv();
      logic        s, a2, a3;
      logic [31:0] d2, d3;
      s  = (init_left != 0);
      a2 = (q2.size() > 0) && (q2[0].due == edge_n) && (i_wb_cycle == 1'b1);
      a3 = (q3.size() > 0) && (q3[0].due == edge_n) && (i_wb_cycle == 1'b1);
      d2 = a2 ? q2[0].data : 32'h0;
      d3 = a3 ? q3[0].data : 32'h0;
      return {s, s, a2, a3, d2, d3};
   endfunction

   task automatic drive(input logic cyc, input logic stb, input logic we,
                        input logic [3:0] sel, input logic [29:0] addr,
                        input logic [31:0] dat);
      i_wb_cycle     = cyc;
      i_wb_stb       = stb;
      i_wb_we        = we;
      i_wb_sel       = sel;
      i_wb_addr      = addr;
      i_wb_mosi_data = dat;
   endtask

   task automatic test_reset();
      int stalls = 0;
      int acks = 0;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL reset_hold i=%0d act=%h exp=%h", i, act, exp); end
         @(negedge clk);
      end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) drive(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 30'($urandom_range(0, 15)), $urandom);
         else        drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL init i=%0d act=%h exp=%h", i, act, exp); end
         if (stall2) stalls++;
         if (ack2 || ack3) acks++;
         @(negedge clk);
      end
      checks++;
      if (stalls != 16) begin failures++; $display("FAIL init_len got=%0d want=16", stalls); end
      checks++;
      if (acks != 0) begin failures++; $display("FAIL init_acks got=%0d want=0", acks); end
   endtask

   task automatic test_init_read();
      logic [15:0] m2 = '0, m3 = '0;
      logic [31:0] d = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) drive(1'b1, 1'b1, 1'b0, 4'h0, 30'd5, 32'h0);
         else        drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL init_read i=%0d act=%h exp=%h", i, act, exp); end
         if (ack2) begin m2[i] = 1'b1; d = miso2; end
         if (ack3) m3[i] = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (m2 !== 16'h0004 || m3 !== 16'h0008)
         begin failures++; $display("FAIL init_read_timing got=%h/%h want=0004/0008", m2, m3); end
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL init_read_data got=%h want=0", d); end
   endtask

   task automatic test_write_read();
      logic [15:0] m2 = '0;
      logic [31:0] dw = 32'hFFFF_FFFF, dr = 32'h0;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0:       drive(1'b1, 1'b1, 1'b1, 4'hF, 30'd3, 32'hDEADBEEF);
            1:       drive(1'b1, 1'b1, 1'b0, 4'hF, 30'd3, 32'h0);
            default: drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         endcase
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL write_read i=%0d act=%h exp=%h", i, act, exp); end
         if (ack2) begin
            m2[i] = 1'b1;
            if (i == 2) dw = miso2;
            if (i == 3) dr = miso2;
         end
         @(negedge clk);
      end
      checks++;
      if (m2 !== 16'h000C) begin failures++; $display("FAIL wr_ack_timing got=%h want=000c", m2); end
      checks++;
      if (dw !== 32'h0) begin failures++; $display("FAIL wr_ack_data got=%h want=0", dw); end
      checks++;
      if (dr !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h want=deadbeef", dr); end
   endtask

   task automatic test_byte_sel();
      logic [31:0] l2 = 32'h0, l3 = 32'h0;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0:       drive(1'b1, 1'b1, 1'b1, 4'hF, 30'd2, 32'h11223344);
            1:       drive(1'b1, 1'b1, 1'b1, 4'h5, 30'd2, 32'hAABBCCDD);
            2:       drive(1'b1, 1'b1, 1'b0, 4'h0, 30'd2, 32'h0);
            default: drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         endcase
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL byte_sel i=%0d act=%h exp=%h", i, act, exp); end
         if (ack2) l2 = miso2;
         if (ack3) l3 = miso3;
         @(negedge clk);
      end
      checks++;
      if (l2 !== 32'h11BB33DD || l3 !== 32'h11BB33DD)
         begin failures++; $display("FAIL byte_sel_data got=%h/%h want=11bb33dd", l2, l3); end
   endtask

   task automatic test_out_of_range();
      int n2 = 0, n3 = 0;
      logic [31:0] orr = 32'h0;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0:       drive(1'b1, 1'b1, 1'b1, 4'hF, 30'd16, 32'h5);
            1:       drive(1'b1, 1'b1, 1'b0, 4'hF, 30'd0, 32'h0);
            2:       drive(1'b1, 1'b1, 1'b0, 4'hF, 30'd16, 32'h0);
            default: drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         endcase
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL oor i=%0d act=%h exp=%h", i, act, exp); end
         if (ack2) begin n2++; orr |= miso2; end
         if (ack3) begin n3++; orr |= miso3; end
         @(negedge clk);
      end
      checks++;
      if (n2 != 3 || n3 != 3) begin failures++; $display("FAIL oor_acks got=%0d/%0d want=3/3", n2, n3); end
      checks++;
      if (orr !== 32'h0) begin failures++; $display("FAIL oor_data got=%h want=0", orr); end
   endtask

   task automatic test_abort();
      logic [15:0] m3 = '0;
      for (int i = 0; i < 12; i++) begin
         if (i < 3)       drive(1'b1, 1'b1, 1'b0, 4'h0, 30'($urandom_range(0, 15)), 32'h0);
         else if (i < 5)  drive(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         else if (i == 5) drive(1'b1, 1'b1, 1'b0, 4'h0, 30'd2, 32'h0);
         else             drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL abort i=%0d act=%h exp=%h", i, act, exp); end
         if (ack3) m3[i] = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (m3 !== 16'h0100) begin failures++; $display("FAIL abort_acks3 got=%h want=0100", m3); end
   endtask

   task automatic test_random();
      logic [29:0] a;
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 9) < 8) ? 30'($urandom_range(0, 15)) : 30'($urandom);
         if (i < 294)
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7), 1'($urandom),
                  4'($urandom), a, $urandom);
         else
            drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL random i=%0d act=%h exp=%h", i, act, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      int stalls, acks;
      // Phase A: reset lands while the init counter is at 7
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
      for (int i = 0; i < 2; i++) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 7; i++) @(negedge clk);
      reset = 1'b0;
      #1;
      act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
      checks++;
      if (act !== exp) begin failures++; $display("FAIL rst_in_init act=%h exp=%h", act, exp); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      stalls = 0; acks = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'($urandom), 1'b0, 4'h0, 30'($urandom_range(0, 15)), 32'h0);
         if (i >= 16) i_wb_stb = 1'b0;
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL reinit_a i=%0d act=%h exp=%h", i, act, exp); end
         if (stall3) stalls++;
         if (ack2 || ack3) acks++;
         @(negedge clk);
      end
      checks++;
      if (stalls != 16 || acks != 0)
         begin failures++; $display("FAIL reinit_a_len got=%0d acks=%0d want=16/0", stalls, acks); end
      // Phase B: reset with two reads in flight
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b0, 4'h0, 30'($urandom_range(0, 15)), 32'h0);
         @(negedge clk);
      end
      drive(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
      reset = 1'b0;
      #1;
      checks++;
      if ({ack2, ack3, stall2, stall3} !== 4'b0011)
         begin failures++; $display("FAIL rst_inflight got=%b want=0011", {ack2, ack3, stall2, stall3}); end
      @(negedge clk);
      reset = 1'b1;
      stalls = 0; acks = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         act = {stall2, stall3, ack2, ack3, miso2, miso3}; exp = expv();
         checks++;
         if (act !== exp) begin failures++; $display("FAIL reinit_b i=%0d act=%h exp=%h", i, act, exp); end
         if (stall2) stalls++;
         if (ack2 || ack3) acks++;
         @(negedge clk);
      end
      checks++;
      if (stalls != 16 || acks != 0)
         begin failures++; $display("FAIL reinit_b_len got=%0d acks=%0d want=16/0", stalls, acks); end
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) mmem[a] = 32'h0;
      @(negedge clk);
      test_reset();
      test_init_read();
      test_write_read();
      test_byte_sel();
      test_out_of_range();
      test_abort();
      test_random();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_ram_responder.md
Name: wb_ram_responder

Overview:
Pipelined Wishbone (B4-style) slave backed by an internal word-addressed RAM. It is the responder end of the bus that the two-master arbiter drives: it accepts one request per cycle and returns acks in order after a fixed latency. After every reset it zero-initialises its memory and stalls the bus until initialisation finishes. It provides scratch/data RAM behind the arbiter.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >= 2; AW = clog2(DEPTH)
LATENCY, 2, cycles from request acceptance to ack; legal range 1..4

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
i_wb_cycle  input  1  bus cycle active
i_wb_stb  input  1  request strobe
i_wb_we  input  1  1 = write, 0 = read
i_wb_sel  input  4  byte enables; bit n selects data[8n+7:8n]
i_wb_addr  input  30  word address
i_wb_mosi_data  input  32  write data
o_wb_ack  output  1  response strobe, one per accepted request
o_wb_stall  output  1  request not accepted this cycle
o_wb_miso_data  output  32  read data, valid when o_wb_ack=1 for a read

Behaviour:
- Reset (reset=0, asynchronous): o_wb_ack=0, o_wb_stall=1, o_wb_miso_data=0, all pipeline entries invalid, FSM -> INIT, init counter=0. Memory contents are not cleared asynchronously; INIT re-zeroes them.
- FSM states: INIT, READY.
- INIT: each cycle writes 0 to word[init counter] and increments the counter; o_wb_stall=1. After word DEPTH-1 is written -> READY. INIT therefore lasts exactly DEPTH cycles after reset release. Requests are ignored and never acked.
- READY: o_wb_stall=0. READY persists until reset.
- Acceptance: a request is accepted at a rising edge where i_wb_cycle=1, i_wb_stb=1 and o_wb_stall=0. Up to one request is accepted per cycle with no bubbles.
- In range: i_wb_addr < DEPTH; the index is i_wb_addr[AW-1:0].
- Write, in range: commits at the acceptance edge. Only bytes with i_wb_sel[n]=1 are updated. sel=0000 is acked and changes nothing.
- Read, in range: returns the full word regardless of sel. It sees every write accepted at earlier edges and does not see a write accepted at the same edge (impossible anyway, since there is one request per edge).
- Out of range (i_wb_addr >= DEPTH, any upper bits set): still accepted and acked. Writes are dropped; reads return 32'h0.
- Latency: a request accepted at edge k raises o_wb_ack for exactly the one cycle following edge k+LATENCY-1. With LATENCY=1, ack is high in the cycle right after acceptance.
- Ack ordering: acks are strictly in acceptance order. N accepted requests produce exactly N ack cycles.
- Pipeline: a LATENCY-deep shift register of {valid, is_read, data}. Read data is captured at acceptance and carried down the pipeline.
- o_wb_miso_data: holds the carried data while o_wb_ack=1. It is 0 when no ack is presented and for write acks.
- Abort: at any edge where i_wb_cycle=0, all in-flight entries become invalid and no later ack is produced for them. Writes already committed are kept.
- Ack gating: o_wb_ack = last_stage_valid & i_wb_cycle, so no ack is ever visible while i_wb_cycle=0.
- Master releasing stb: i_wb_stb=0 with i_wb_cycle=1 accepts nothing; in-flight acks still drain normally.
- Reset mid-operation: in-flight requests are discarded without acks, and a full INIT pass runs again.

Test Plan:
- DEPTH=16: hold reset low for 3 cycles, then release -> o_wb_stall=1 for exactly 16 cycles, then 0. No ack for any stb driven during INIT. A subsequent read of addr 5 returns 32'h0.
- LATENCY=2: write 32'hDEADBEEF to addr 3 at edge k, read addr 3 at edge k+1 -> acks in the cycles after edges k+1 and k+2. The second ack has miso=32'hDEADBEEF; the write ack has miso=0.
- Write 32'h11223344 sel=1111 to addr 2, then write 32'hAABBCCDD sel=0101, then read addr 2 -> 32'h11BB33DD.
- DEPTH=16: write 32'h5 to addr 16 (0x10), then read addr 0 and addr 16 -> three acks. Addr 0 reads 0 (after INIT) and addr 16 reads 0.
- LATENCY=3: issue 3 back-to-back reads, drop i_wb_cycle at the edge after the third acceptance, then hold it low 2 cycles and raise it again -> zero acks observed. A new read is acked exactly 3 cycles after acceptance.
- Assert reset during INIT (counter=7), and separately with 2 reads in flight -> ack drops immediately and stall=1. No stale acks appear, and a full DEPTH-cycle INIT repeats.
